modmul_arbiter: RTL and testbench



---
 rtl/modmul_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_modmul_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modmul_arbiter.sv
// Two-requester round-robin front end sharing one pipelined Barrett modular multiplier.
// Define MODMUL_ARB_STATS_EN to build the grant/conflict counters; otherwise they read 0.
module modmul_arbiter #(
    parameter int unsigned     Q     = 8380417,
    parameter int unsigned     K     = 23,
    parameter longint unsigned MU    = 8396807,
    parameter int unsigned     LAT   = 3,
    parameter int unsigned     TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    output logic [31:0]      rsp0_result,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    output logic [31:0]      rsp1_result,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic             busy,
    output logic [31:0]      stat_grant0,
    output logic [31:0]      stat_grant1,
    output logic [31:0]      stat_conflict
);

    // Capture and output registers account for two cycles; the rest carry the product.
    localparam int unsigned NMID = LAT - 2;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic grant0;
    logic grant1;
    logic ptr_q;
    logic conflict;

    assign conflict = en && req0_valid && req1_valid;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && en) begin
            if (req0_valid && req1_valid) begin
                grant0 = ptr_q;
                grant1 = !ptr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // ptr_q holds the index of the last granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else if (grant0) begin
            ptr_q <= 1'b0;
        end else if (grant1) begin
            ptr_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    logic             cap_valid_q;
    logic             cap_idx_q;
    logic [31:0]      cap_a_q;
    logic [31:0]      cap_b_q;
    logic [TAG_W-1:0] cap_tag_q;
    logic [63:0]      prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_idx_q   <= 1'b0;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            cap_tag_q   <= '0;
        end else begin
            cap_valid_q <= grant0 || grant1;
            if (grant0 || grant1) begin
                cap_idx_q <= grant1;
                cap_a_q   <= grant1 ? req1_a : req0_a;
                cap_b_q   <= grant1 ? req1_b : req0_b;
                cap_tag_q <= grant1 ? req1_tag : req0_tag;
            end
        end
    end

    assign prod = {32'd0, cap_a_q} * {32'd0, cap_b_q};

    // ------------------------------------------------------------------
    // Product delay stages feeding the reduction
    // ------------------------------------------------------------------
    logic             red_valid;
    logic             red_idx;
    logic [TAG_W-1:0] red_tag;
    logic [63:0]      red_prod;
    logic             mid_busy;

    if (NMID == 0) begin : g_no_mid
        assign red_valid = cap_valid_q;
        assign red_idx   = cap_idx_q;
        assign red_tag   = cap_tag_q;
        assign red_prod  = prod;
        assign mid_busy  = 1'b0;
    end else begin : g_mid
        logic [NMID-1:0]            mid_valid_q;
        logic [NMID-1:0]            mid_idx_q;
        logic [NMID-1:0][TAG_W-1:0] mid_tag_q;
        logic [NMID-1:0][63:0]      mid_prod_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mid_valid_q <= '0;
                mid_idx_q   <= '0;
                mid_tag_q   <= '0;
                mid_prod_q  <= '0;
            end else begin
                mid_valid_q[0] <= cap_valid_q;
                mid_idx_q[0]   <= cap_idx_q;
                mid_tag_q[0]   <= cap_tag_q;
                mid_prod_q[0]  <= prod;
                for (int unsigned i = 1; i < NMID; i++) begin
                    mid_valid_q[i] <= mid_valid_q[i-1];
                    mid_idx_q[i]   <= mid_idx_q[i-1];
                    mid_tag_q[i]   <= mid_tag_q[i-1];
                    mid_prod_q[i]  <= mid_prod_q[i-1];
                end
            end
        end

        assign red_valid = mid_valid_q[NMID-1];
        assign red_idx   = mid_idx_q[NMID-1];
        assign red_tag   = mid_tag_q[NMID-1];
        assign red_prod  = mid_prod_q[NMID-1];
        assign mid_busy  = |mid_valid_q;
    end

    // ------------------------------------------------------------------
    // Barrett reduction: estimate leaves r < 3Q, two conditional subtracts finish it.
    // ------------------------------------------------------------------
    logic [63:0] red_q1;
    logic [63:0] red_q3;
    logic [31:0] red_r0;
    logic [31:0] red_r1;
    logic [31:0] red_result;

    always_comb begin
        red_q1     = red_prod >> (K - 1);
        red_q3     = (red_q1 * MU) >> (K + 1);
        red_r0     = 32'(red_prod - red_q3 * 64'(Q));
        red_r1     = (red_r0 >= Q) ? red_r0 - Q : red_r0;
        red_result = (red_r1 >= Q) ? red_r1 - Q : red_r1;
    end

    // ------------------------------------------------------------------
    // Response registers: strobe on the owning index, data held otherwise
    // ------------------------------------------------------------------
    logic [1:0]            rsp_valid_q;
    logic [1:0][31:0]      rsp_result_q;
    logic [1:0][TAG_W-1:0] rsp_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (red_valid) begin
                rsp_valid_q[red_idx]  <= 1'b1;
                rsp_result_q[red_idx] <= red_result;
                rsp_tag_q[red_idx]    <= red_tag;
            end
        end
    end

    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp0_result = rsp_result_q[0];
    assign rsp1_result = rsp_result_q[1];
    assign rsp0_tag    = rsp_tag_q[0];
    assign rsp1_tag    = rsp_tag_q[1];

    assign busy = cap_valid_q || mid_busy || (|rsp_valid_q);

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef MODMUL_ARB_STATS_EN
    logic [31:0] grant0_cnt_q;
    logic [31:0] grant1_cnt_q;
    logic [31:0] conflict_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant0_cnt_q   <= '0;
            grant1_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (grant0 && grant0_cnt_q != '1) begin
                grant0_cnt_q <= grant0_cnt_q + 32'd1;
            end
            if (grant1 && grant1_cnt_q != '1) begin
                grant1_cnt_q <= grant1_cnt_q + 32'd1;
            end
            if (conflict && conflict_cnt_q != '1) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign stat_grant0   = grant0_cnt_q;
    assign stat_grant1   = grant1_cnt_q;
    assign stat_conflict = conflict_cnt_q;
`else
    logic unused_conflict;
    assign unused_conflict = conflict;
    assign stat_grant0     = '0;
    assign stat_grant1     = '0;
    assign stat_conflict   = '0;
`endif

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed and random checks of modmul_arbiter: arbitration, latency, results, reset.
module tb_modmul_arbiter;

    localparam int unsigned     Q     = 8380417;
    localparam int unsigned     K     = 23;
    localparam longint unsigned MU    = 8396807;
    localparam int unsigned     LAT   = 3;
    localparam int unsigned     TAG_W = 4;
`ifdef MODMUL_ARB_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             rsp0_valid, rsp1_valid;
    logic [31:0]      rsp0_result, rsp1_result;
    logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
    logic             busy;
    logic [31:0]      stat_grant0, stat_grant1, stat_conflict;

    modmul_arbiter #(
        .Q     (Q),
        .K     (K),
        .MU    (MU),
        .LAT   (LAT),
        .TAG_W (TAG_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req0_tag      (req0_tag),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .req1_tag      (req1_tag),
        .rsp0_valid    (rsp0_valid),
        .rsp0_result   (rsp0_result),
        .rsp0_tag      (rsp0_tag),
        .rsp1_valid    (rsp1_valid),
        .rsp1_result   (rsp1_result),
        .rsp1_tag      (rsp1_tag),
        .busy          (busy),
        .stat_grant0   (stat_grant0),
        .stat_grant1   (stat_grant1),
        .stat_conflict (stat_conflict)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_mod(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return 32'(p % 64'(Q));
    endfunction

    // Scoreboard: expected responses per requester, plus an ordered log of all responses.
    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    exp_t        exp0_q[$];
    exp_t        exp1_q[$];
    int          log_idx[$];
    int          log_cyc[$];
    logic [31:0] log_res[$];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_rsp(input int idx, input logic [31:0] res, input logic [TAG_W-1:0] tag);
        exp_t e;
        int   pending;
        log_idx.push_back(idx);
        log_cyc.push_back(cyc);
        log_res.push_back(res);
        pending = (idx == 0) ? exp0_q.size() : exp1_q.size();
        check_eq($sformatf("rsp%0d_pending", idx), 64'(pending != 0), 64'd1);
        if (pending != 0) begin
            if (idx == 0) e = exp0_q.pop_front();
            else          e = exp1_q.pop_front();
            check_eq($sformatf("rsp%0d_result", idx), 64'(res), 64'(e.res));
            check_eq($sformatf("rsp%0d_tag", idx), 64'(tag), 64'(e.tag));
            check_eq($sformatf("rsp%0d_cycle", idx), 64'(cyc), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            if (rsp0_valid) check_rsp(0, rsp0_result, rsp0_tag);
            if (rsp1_valid) check_rsp(1, rsp1_result, rsp1_tag);
            if (req0_valid && req0_ready)
                exp0_q.push_back('{ref_mod(req0_a, req0_b), req0_tag, cyc + int'(LAT)});
            if (req1_valid && req1_ready)
                exp1_q.push_back('{ref_mod(req1_a, req1_b), req1_tag, cyc + int'(LAT)});
        end
    end

    int   base;
    int   n_new;
    logic m_ptr;
    logic exp_r0, exp_r1;
    int   m_g0, m_g1, m_conf;

    initial begin
        rst = 1'b1; en = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_tag = '0;
        repeat (2) tick();

        // Reset state, including ready held low while requests are presented
        en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_eq("rst_ready0", 64'(req0_ready), 64'd0);
        check_eq("rst_ready1", 64'(req1_ready), 64'd0);
        check_eq("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
        check_eq("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rsp0_result", 64'(rsp0_result), 64'd0);
        check_eq("rst_rsp1_tag", 64'(rsp1_tag), 64'd0);
        check_eq("rst_stat_grant0", 64'(stat_grant0), 64'd0);
        check_eq("rst_stat_conflict", 64'(stat_conflict), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Requester 0 alone: 3*5 = 15, tag 7, three cycles after acceptance
        req0_a = 32'd3; req0_b = 32'd5; req0_tag = 4'd7; req0_valid = 1'b1;
        #1;
        check_eq("t1_ready0", 64'(req0_ready), 64'd1);
        check_eq("t1_ready1", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0;
        check_eq("t1_busy", 64'(busy), 64'd1);
        check_eq("t1_early_a", 64'(rsp0_valid), 64'd0);
        tick();
        check_eq("t1_early_b", 64'(rsp0_valid), 64'd0);
        tick();
        check_eq("t1_valid", 64'(rsp0_valid), 64'd1);
        check_eq("t1_result", 64'(rsp0_result), 64'd15);
        check_eq("t1_tag", 64'(rsp0_tag), 64'd7);
        check_eq("t1_rsp1_quiet", 64'(rsp1_valid), 64'd0);
        tick();
        check_eq("t1_strobe", 64'(rsp0_valid), 64'd0);
        check_eq("t1_hold_result", 64'(rsp0_result), 64'd15);
        check_eq("t1_hold_tag", 64'(rsp0_tag), 64'd7);

        // Requester 1: (Q-1)^2 mod Q = 1, then 4190209*2 = Q+1 -> 1, back to back
        req1_a = Q - 1; req1_b = Q - 1; req1_tag = 4'd3; req1_valid = 1'b1;
        #1;
        check_eq("t2_ready1_a", 64'(req1_ready), 64'd1);
        tick();
        req1_a = 32'd4190209; req1_b = 32'd2; req1_tag = 4'd4;
        #1;
        check_eq("t2_ready1_b", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        check_eq("t2_valid_a", 64'(rsp1_valid), 64'd1);
        check_eq("t2_result_a", 64'(rsp1_result), 64'd1);
        check_eq("t2_tag_a", 64'(rsp1_tag), 64'd3);
        check_eq("t2_rsp0_quiet", 64'(rsp0_valid), 64'd0);
        tick();
        check_eq("t2_valid_b", 64'(rsp1_valid), 64'd1);
        check_eq("t2_result_b", 64'(rsp1_result), 64'd1);
        check_eq("t2_tag_b", 64'(rsp1_tag), 64'd4);
        tick();
        check_eq("t2_strobe", 64'(rsp1_valid), 64'd0);

        // Contention from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = log_idx.size();
        for (int i = 0; i < 4; i++) begin
            req0_a = 32'd2; req0_b = 32'd3; req0_tag = 4'(i);     req0_valid = 1'b1;
            req1_a = 32'd4; req1_b = 32'd5; req1_tag = 4'(8 + i); req1_valid = 1'b1;
            #1;
            check_eq($sformatf("t3_ready0_%0d", i), 64'(req0_ready), 64'(i % 2 == 0));
            check_eq($sformatf("t3_ready1_%0d", i), 64'(req1_ready), 64'(i % 2 == 1));
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq("t3_stat_conflict", 64'(stat_conflict), StatsEn ? 64'd4 : 64'd0);
        check_eq("t3_stat_grant0", 64'(stat_grant0), StatsEn ? 64'd2 : 64'd0);
        check_eq("t3_stat_grant1", 64'(stat_grant1), StatsEn ? 64'd2 : 64'd0);
        repeat (5) tick();
        n_new = log_idx.size() - base;
        check_eq("t3_rsp_count", 64'(n_new), 64'd4);
        for (int j = 0; j < 4 && j < n_new; j++) begin
            check_eq($sformatf("t3_order_%0d", j), 64'(log_idx[base + j]), 64'(j % 2));
            check_eq($sformatf("t3_result_%0d", j), 64'(log_res[base + j]),
                     (j % 2 == 1) ? 64'd20 : 64'd6);
            check_eq($sformatf("t3_b2b_%0d", j), 64'(log_cyc[base + j] - log_cyc[base]), 64'(j));
        end

        // Three issues, then en=0 with both valid: no more grants, in-flight work drains
        base = log_idx.size();
        for (int i = 0; i < 3; i++) begin
            req0_a = 32'(i + 1); req0_b = 32'd10; req0_tag = 4'(i); req0_valid = 1'b1;
            #1;
            check_eq($sformatf("t4_ready0_%0d", i), 64'(req0_ready), 64'd1);
            tick();
        end
        check_eq("t4_busy", 64'(busy), 64'd1);
        en = 1'b0; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("t4_noready0_%0d", i), 64'(req0_ready), 64'd0);
            check_eq($sformatf("t4_noready1_%0d", i), 64'(req1_ready), 64'd0);
            tick();
        end
        n_new = log_idx.size() - base;
        check_eq("t4_rsp_count", 64'(n_new), 64'd3);
        for (int j = 0; j < 3 && j < n_new; j++) begin
            check_eq($sformatf("t4_result_%0d", j), 64'(log_res[base + j]), 64'(10 * (j + 1)));
        end
        check_eq("t4_busy_done", 64'(busy), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0; en = 1'b1;
        tick();

        // Reset with two operations in flight: nothing may emerge
        req1_a = 32'd100; req1_b = 32'd100; req1_tag = 4'd5; req1_valid = 1'b1;
        #1;
        check_eq("t5_ready1_a", 64'(req1_ready), 64'd1);
        tick();
        #1;
        check_eq("t5_ready1_b", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("t5_busy_in_rst", 64'(busy), 64'd0);
        base = log_idx.size();
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        check_eq("t5_no_rsp", 64'(log_idx.size() - base), 64'd0);
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_stat_grant0", 64'(stat_grant0), 64'd0);
        check_eq("t5_stat_grant1", 64'(stat_grant1), 64'd0);
        check_eq("t5_stat_conflict", 64'(stat_conflict), 64'd0);

        // Random traffic against a reference arbiter and the scoreboard
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 1'b1; m_g0 = 0; m_g1 = 0; m_conf = 0;
        for (int c = 0; c < 10000; c++) begin
            en         = ($urandom_range(0, 3) != 0);
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a     = $urandom_range(0, Q - 1);
            req0_b     = $urandom_range(0, Q - 1);
            req1_a     = $urandom_range(0, Q - 1);
            req1_b     = $urandom_range(0, Q - 1);
            req0_tag   = 4'($urandom);
            req1_tag   = 4'($urandom);
            #1;
            exp_r0 = en && req0_valid && (!req1_valid || m_ptr);
            exp_r1 = en && req1_valid && (!req0_valid || !m_ptr);
            check_eq("rand_ready0", 64'(req0_ready), 64'(exp_r0));
            check_eq("rand_ready1", 64'(req1_ready), 64'(exp_r1));
            if (exp_r0) begin
                m_ptr = 1'b0;
                m_g0++;
            end
            if (exp_r1) begin
                m_ptr = 1'b1;
                m_g1++;
            end
            if (en && req0_valid && req1_valid) m_conf++;
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (LAT + 3) tick();
        check_eq("rand_lost0", 64'(exp0_q.size()), 64'd0);
        check_eq("rand_lost1", 64'(exp1_q.size()), 64'd0);
        check_eq("rand_busy", 64'(busy), 64'd0);
        check_eq("rand_stat_grant0", 64'(stat_grant0), StatsEn ? 64'(m_g0) : 64'd0);
        check_eq("rand_stat_grant1", 64'(stat_grant1), StatsEn ? 64'(m_g1) : 64'd0);
        check_eq("rand_stat_conflict", 64'(stat_conflict), StatsEn ? 64'(m_conf) : 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
